tff_bist_ctrl: RTL

TFF_BIST_CTRL -- requirements
Module: tff_bist_ctrl

---
 rtl/tff_bist_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tff_bist_ctrl.sv
// BIST sequencer for a bank of T flip-flops: clears the bank, applies k = 0..NUM_ITER-1
// as toggle patterns and checks each response against a running XOR model of the bank.
module tff_bist_ctrl #(
    parameter int WIDTH    = 4,
    parameter int NUM_ITER = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_vec,
    output logic [WIDTH-1:0] t_vec,
    output logic             tff_clear,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [7:0]       fail_cnt,
    output logic [WIDTH-1:0] fail_mask
);

    localparam int KW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_ITER - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CLR     = 3'd1;
    localparam logic [2:0] CHK_CLR = 3'd2;
    localparam logic [2:0] APPLY   = 3'd3;
    localparam logic [2:0] CHECK   = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] t_vec_q, t_vec_d;
    logic             tff_clear_q, tff_clear_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [7:0]       fail_cnt_q, fail_cnt_d;
    logic [WIDTH-1:0] fail_mask_q, fail_mask_d;

    logic             cmp_en;
    logic [WIDTH-1:0] cmp_ref;
    logic [WIDTH-1:0] cmp_diff;
    logic [KW+WIDTH-1:0] k_wide;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        exp_d       = exp_q;
        fault_d     = fault_q;
        fail_cnt_d  = fail_cnt_q;
        fail_mask_d = fail_mask_q;
        cmp_en      = 1'b0;
        cmp_ref     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CLR;
                    k_d         = '0;
                    exp_d       = '0;
                    fault_d     = 1'b0;
                    fail_cnt_d  = 8'd0;
                    fail_mask_d = '0;
                end
            end
            CLR: begin
                exp_d   = '0;
                state_d = CHK_CLR;
            end
            CHK_CLR: begin
                cmp_en  = 1'b1;
                state_d = APPLY;
            end
            APPLY: begin
                exp_d   = exp_q ^ t_vec_q;
                state_d = CHECK;
            end
            CHECK: begin
                cmp_en  = 1'b1;
                cmp_ref = exp_q;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = APPLY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including the compare of the current cycle.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            k_d     = k_q;
            exp_d   = exp_q;
            cmp_en  = 1'b0;
        end

        cmp_diff = q_vec ^ cmp_ref;
        if (cmp_en && (cmp_diff != '0)) begin
            fault_d     = 1'b1;
            fail_cnt_d  = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
            fail_mask_d = fail_mask_q | cmp_diff;
        end

        // Outputs are decoded from the next state so they line up with the state register.
        k_wide      = {{WIDTH{1'b0}}, k_d};
        t_vec_d     = (state_d == APPLY) ? k_wide[WIDTH-1:0] : '0;
        tff_clear_d = (state_d == CLR);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            k_q         <= '0;
            exp_q       <= '0;
            t_vec_q     <= '0;
            tff_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            fail_cnt_q  <= 8'd0;
            fail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            exp_q       <= exp_d;
            t_vec_q     <= t_vec_d;
            tff_clear_q <= tff_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign t_vec     = t_vec_q;
    assign tff_clear = tff_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign fail_cnt  = fail_cnt_q;
    assign fail_mask = fail_mask_q;

endmodule
